gauss_rng_clt: RTL and testbench

Parametrised multi-lane Gaussian pseudo-random generator for the BNN weight/noise sampling datapath, exposed through the OpenCL HDL library handshake (ivalid/iready/ovalid/oready). LANES independent Galois LFSRs each produce a uniform sample. Their truncated outputs are summed in a registered adder tree to form an approximately Gaussian, zero-centred, signed fixed-point value (central limit theorem). A mode input selects a plain uniform output instead. The block supports per-lane seeding, zero-seed protection and downstream back-pressure.

---
 rtl/gauss_rng_clt_if.sv | 28 ++
 rtl/gauss_rng_clt.sv | 128 ++++++++++++
 tb/tb_gauss_rng_clt.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gauss_rng_clt_if.sv
// Request/response handshake and seeding bundle for gauss_rng_clt.
// The master side issues requests and consumes samples; the slave side is the generator.
interface gauss_rng_clt_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int UBITS = 8
);
  localparam int OUT_W = UBITS + $clog2(LANES);

  logic                      ivalid;
  logic                      iready;
  logic                      oready;
  logic                      ovalid;
  logic                      load;
  logic                      mode;
  logic [LANES*WIDTH-1:0]    seed;
  logic signed [OUT_W-1:0]   dout;

  modport master (
    output ivalid, iready, load, seed, mode,
    input  oready, ovalid, dout
  );

  modport slave (
    input  ivalid, iready, load, seed, mode,
    output oready, ovalid, dout
  );
endinterface

// File: rtl/gauss_rng_clt.sv
// Multi-lane Galois-LFSR Gaussian sampler: lane uniforms summed through an adder tree
// and re-centred to a signed value, or lane 0 alone in uniform mode.
module gauss_rng_clt #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'hB400,
  parameter int              LANES = 4,
  parameter int              UBITS = 8
) (
  input logic             clock,
  input logic             resetn,
  gauss_rng_clt_if.slave  bus
);
  localparam int               OUT_W   = UBITS + $clog2(LANES);
  localparam int               NODES   = 2 * LANES - 1;
  localparam logic [OUT_W-1:0] LANES_W = OUT_W'(LANES);
  // Centre of the lane sum; equals 2^(OUT_W-1) because LANES is a power of two.
  localparam logic [OUT_W-1:0] OFFSET  = LANES_W << (UBITS - 1);
  localparam logic [UBITS-1:0] HALF    = {1'b1, {(UBITS-1){1'b0}}};

  logic [WIDTH-1:0]       lane_r      [LANES];
  logic [WIDTH-1:0]       lane_next_s [LANES];
  logic [LANES*UBITS-1:0] terms_s;
  logic [OUT_W-1:0]       gauss_s;
  logic [UBITS-1:0]       centred_s;
  logic [OUT_W-1:0]       uni_s;
  logic [OUT_W-1:0]       result_s;
  logic                   v1_r;
  logic                   mode1_r;
  logic                   ovalid_r;
  logic signed [OUT_W-1:0] dout_r;
  logic                   en_s;
  logic                   oready_s;
  logic                   accept_s;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : {WIDTH{1'b0}});
  endfunction

  function automatic logic [OUT_W-1:0] tree_sum(input logic [LANES*UBITS-1:0] terms);
    logic [OUT_W-1:0] node [NODES];
    for (int k = 0; k < LANES; k++) begin
      node[LANES-1+k] = OUT_W'(terms[k*UBITS +: UBITS]);
    end
    for (int k = LANES - 2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    return node[0];
  endfunction

  assign en_s     = ~ovalid_r | bus.iready;
  assign oready_s = en_s & ~bus.load;
  assign accept_s = bus.ivalid & oready_s;

  // Next lane state: seed load wins over stepping; a zero seed would lock the LFSR.
  always_comb begin
    lane_next_s = lane_r;
    for (int i = 0; i < LANES; i++) begin
      if (bus.load) begin
        if (bus.seed[i*WIDTH +: WIDTH] == {WIDTH{1'b0}}) begin
          lane_next_s[i] = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          lane_next_s[i] = bus.seed[i*WIDTH +: WIDTH];
        end
      end else if (accept_s) begin
        lane_next_s[i] = lfsr_step(lane_r[i]);
      end else begin
        lane_next_s[i] = lane_r[i];
      end
    end
  end

  // Lane state registers; reset gives each lane a distinct non-zero start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LANES; i++) begin
        lane_r[i] <= WIDTH'(i + 1);
      end
    end else begin
      lane_r <= lane_next_s;
    end
  end

  // Gather the top UBITS of every lane into one packed term vector.
  always_comb begin
    terms_s = {(LANES*UBITS){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      terms_s[i*UBITS +: UBITS] = lane_r[i][WIDTH-1 -: UBITS];
    end
  end

  // Re-centre both candidates and pick the one requested with this sample.
  always_comb begin
    gauss_s   = tree_sum(terms_s) - OFFSET;
    centred_s = lane_r[0][WIDTH-1 -: UBITS] - HALF;
    uni_s     = {{(OUT_W-UBITS){centred_s[UBITS-1]}}, centred_s};
    if (mode1_r) begin
      result_s = uni_s;
    end else begin
      result_s = gauss_s;
    end
  end

  // Two-stage valid pipeline; dout only moves when a real sample advances.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1_r     <= 1'b0;
      mode1_r  <= 1'b0;
      ovalid_r <= 1'b0;
      dout_r   <= {OUT_W{1'b0}};
    end else if (bus.load) begin
      v1_r     <= 1'b0;
      ovalid_r <= 1'b0;
    end else if (en_s) begin
      v1_r     <= accept_s;
      ovalid_r <= v1_r;
      if (v1_r) begin
        dout_r <= result_s;
      end
      if (accept_s) begin
        mode1_r <= bus.mode;
      end
    end
  end

  assign bus.oready = oready_s;
  assign bus.ovalid = ovalid_r;
  assign bus.dout   = dout_r;
endmodule

// File: tb/tb_gauss_rng_clt.sv
// Self-checking bench for gauss_rng_clt: directed vector table, period, stall,
// load/reset corner sequences, and randomized traffic against a transaction-level model.
module tb_gauss_rng_clt;
  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int UBITS = 8;

  typedef struct {
    logic [15:0] lane_seed;
    logic        md;
    int          exp;
  } vec_t;

  typedef struct {
    int     val;
    longint ready;
  } smp_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  gauss_rng_clt_if #(.WIDTH(WIDTH), .LANES(LANES), .UBITS(UBITS)) bus ();

  gauss_rng_clt #(.WIDTH(WIDTH), .POLY(16'hB400), .LANES(LANES), .UBITS(UBITS)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  int          n_out = 0;
  int          last_out = 0;
  logic        hold_pending = 1'b0;
  int          hold_dout = 0;
  logic [15:0] m_lane [LANES];
  smp_t        q [$];
  vec_t        vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dout_i();
    return int'($signed(bus.dout));
  endfunction

  // Reference model: the LFSR rule written as plain arithmetic on integers.
  function automatic logic [15:0] next_state(input logic [15:0] s);
    int v;
    v = int'(s) / 2;
    if (int'(s) % 2 == 1) v = v ^ 32'h0000B400;
    return v[15:0];
  endfunction

  function automatic int model_sample(input logic md);
    int sum;
    sum = 0;
    for (int i = 0; i < LANES; i++) sum += int'(m_lane[i]) / 256;
    if (md) return int'(m_lane[0]) / 256 - 128;
    return sum - 512;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_lane[i] = 16'(i + 1);
    q.delete();
    hold_pending = 1'b0;
  endtask

  task automatic drive_cycle(input logic iv, input logic ir, input logic md,
                             input logic ld, input logic [63:0] sd);
    smp_t e;
    @(negedge clock);
    bus.ivalid = iv;
    bus.iready = ir;
    bus.mode   = md;
    bus.load   = ld;
    bus.seed   = sd;
    #1;
    cyc++;
    if (hold_pending) begin
      check("hold_ovalid", int'(bus.ovalid), 1);
      check("hold_dout", dout_i(), hold_dout);
    end
    check("oready", int'(bus.oready), int'(!(bus.ovalid && !ir) && !ld));
    if (q.size() == 0) begin
      check("spurious_ovalid", int'(bus.ovalid), 0);
    end else if (bus.ovalid && ir) begin
      e = q.pop_front();
      check("sample", dout_i(), e.val);
      last_out = dout_i();
      n_out++;
    end
    hold_pending = bus.ovalid && !ir && !ld;
    hold_dout    = dout_i();
    if (ld) begin
      q.delete();
      for (int i = 0; i < LANES; i++) begin
        m_lane[i] = (sd[i*16 +: 16] == 16'h0000) ? 16'h0001 : sd[i*16 +: 16];
      end
    end else if (iv && bus.oready) begin
      for (int i = 0; i < LANES; i++) m_lane[i] = next_state(m_lane[i]);
      e.val   = model_sample(md);
      e.ready = cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic async_reset();
    @(negedge clock);
    #3;
    resetn = 1'b0;
    #1;
    check("rst_ovalid", int'(bus.ovalid), 0);
    check("rst_dout", dout_i(), 0);
    check("rst_oready", int'(bus.oready), 1);
    model_reset();
    @(negedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic single_request(input logic md, input int exp, input string name);
    drive_cycle(1'b1, 1'b1, md, 1'b0, 64'h0);
    check({name, "_t0"}, int'(bus.ovalid), 0);
    drive_cycle(1'b0, 1'b1, md, 1'b0, 64'h0);
    check({name, "_t1"}, int'(bus.ovalid), 0);
    drive_cycle(1'b0, 1'b1, md, 1'b0, 64'h0);
    check({name, "_t2_ovalid"}, int'(bus.ovalid), 1);
    check({name, "_t2_dout"}, dout_i(), exp);
  endtask

  initial begin
    int         mark;
    logic [63:0] sd;
    logic        ir;

    vecs[0] = '{16'h0001, 1'b0, 208};
    vecs[1] = '{16'h0001, 1'b1, 52};
    vecs[2] = '{16'h0000, 1'b0, 208};
    vecs[3] = '{16'h0000, 1'b1, 52};
    vecs[4] = '{16'hFFFF, 1'b0, 300};
    vecs[5] = '{16'hFFFF, 1'b1, 75};
    vecs[6] = '{16'h8000, 1'b0, -256};
    vecs[7] = '{16'h0002, 1'b0, -512};
    vecs[8] = '{16'h9601, 1'b0, 508};
    vecs[9] = '{16'h9601, 1'b1, 127};

    bus.ivalid = 1'b0;
    bus.iready = 1'b1;
    bus.mode   = 1'b0;
    bus.load   = 1'b0;
    bus.seed   = 64'h0;
    model_reset();
    async_reset();

    // Reset lane values 1,2,3,4 give u = 180,0,180,0.
    single_request(1'b0, -152, "reset_lanes");

    for (int i = 0; i < 10; i++) begin
      sd = {4{vecs[i].lane_seed}};
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, sd);
      single_request(vecs[i].md, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Full period of lane 0 in uniform mode at one accept per cycle.
    sd = {4{16'h0001}};
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, sd);
    mark = n_out;
    for (int k = 0; k < 65535; k++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 64'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    check("period_count", n_out - mark, 65535);
    check("period_last_is_seed", last_out, -128);
    single_request(1'b1, 52, "period_wrap");

    // Continuous requests with iready 1,0,0,1.
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, sd);
    mark = n_out;
    for (int k = 0; k < 16; k++) begin
      ir = (k % 4 == 0) || (k % 4 == 3);
      drive_cycle(1'b1, ir, 1'b0, 1'b0, 64'h0);
    end
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    check("stall_drain_empty", int'(q.size()), 0);

    // Load together with ivalid: nothing accepted.
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b1, sd);
    check("load_oready", int'(bus.oready), 0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    check("load_no_accept_t1", int'(bus.ovalid), 0);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    check("load_no_accept_t2", int'(bus.ovalid), 0);

    // Build a held sample, then reset mid-stream.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    check("pre_reset_ovalid", int'(bus.ovalid), 1);
    check("pre_reset_dout", dout_i(), 208);
    async_reset();
    single_request(1'b0, -152, "post_reset_lanes");

    // Randomized traffic, mixed modes, occasional reloads with zero lanes.
    for (int i = 0; i < LANES; i++) begin
      sd[i*16 +: 16] = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, sd);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        for (int i = 0; i < LANES; i++) begin
          sd[i*16 +: 16] = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
        end
        drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, sd);
      end else begin
        drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), 1'b0, 64'h0);
      end
    end
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    check("random_drain_empty", int'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
